// File: rtl/eth_fcs_pkg.sv
// Shared Ethernet FCS definitions: CRC-32 constants, checker state encoding
// and the byte-wide reflected CRC-32 step used by the RX checker and TX inserter.
package eth_fcs_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;
  localparam int          FCS_LEN       = 4;

  typedef enum logic [1:0] {
    SKIP  = 2'd0,
    IDLE  = 2'd1,
    FRAME = 2'd2
  } fcs_state_t;

  // Reflected CRC-32 update for one byte, least significant bit first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) begin
        c = {1'b0, c[31:1]} ^ CRC32_POLY;
      end else begin
        c = {1'b0, c[31:1]};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational byte-wide CRC-32 (reflected, poly 0xEDB88320) next-state logic.
module crc32_d8
  import eth_fcs_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  // Next CRC value after absorbing data_i.
  always_comb begin
    crc_o = crc32_byte(crc_i, data_i);
  end

endmodule

// File: rtl/rx_fcs_check.sv
// Receive FCS checker: runs CRC-32 over every post-SFD byte, strips the
// trailing 4 FCS bytes through a 4-deep delay line and reports FCS error,
// runt and frame length on a one-cycle end-of-frame pulse.
// Optional: define RX_FCS_STATS_EN to add saturating frame / FCS-error counters.
module rx_fcs_check
  import eth_fcs_pkg::*;
#(
  parameter int MIN_FRAME_LEN = 64,
  parameter int LEN_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [7:0]       data_i,
  input  logic             er_i,
  output logic             valid_o,
  output logic [7:0]       data_o,
  output logic             er_o,
  output logic             eof_o,
  output logic             fcs_error_o,
  output logic             runt_o,
  output logic [LEN_W-1:0] frame_len_o
`ifdef RX_FCS_STATS_EN
  ,
  output logic [31:0]      stat_frames_o,
  output logic [31:0]      stat_fcs_err_o
`endif
);

  localparam logic [LEN_W-1:0] LEN_MAX_C = {LEN_W{1'b1}};
  localparam logic [LEN_W-1:0] FCS_LEN_C = LEN_W'(FCS_LEN);
  localparam logic [LEN_W-1:0] MIN_LEN_C = LEN_W'(MIN_FRAME_LEN);

  fcs_state_t       state_r;
  logic [31:0]      crc_r;
  logic [31:0]      crc_seed_s;
  logic [31:0]      crc_next_s;
  logic [LEN_W-1:0] count_r;
  logic [3:0][7:0]  dl_data_r;
  logic [3:0]       dl_er_r;

  // First byte of a frame starts from the init value; later bytes chain on.
  always_comb begin
    if (state_r == IDLE) begin
      crc_seed_s = CRC32_INIT;
    end else begin
      crc_seed_s = crc_r;
    end
  end

  crc32_d8 u_crc (
    .crc_i  (crc_seed_s),
    .data_i (data_i),
    .crc_o  (crc_next_s)
  );

  // Delay line holding the last four {data, er} pairs of the current frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      dl_data_r <= '0;
      dl_er_r   <= 4'd0;
    end else if (valid_i && (state_r != SKIP)) begin
      dl_data_r <= {dl_data_r[2:0], data_i};
      dl_er_r   <= {dl_er_r[2:0], er_i};
    end else begin
      dl_data_r <= dl_data_r;
      dl_er_r   <= dl_er_r;
    end
  end

  // Frame state machine, CRC/length tracking and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= SKIP;
      crc_r       <= CRC32_INIT;
      count_r     <= '0;
      valid_o     <= 1'b0;
      data_o      <= 8'd0;
      er_o        <= 1'b0;
      eof_o       <= 1'b0;
      fcs_error_o <= 1'b0;
      runt_o      <= 1'b0;
      frame_len_o <= '0;
    end else begin
      valid_o     <= 1'b0;
      eof_o       <= 1'b0;
      fcs_error_o <= 1'b0;
      runt_o      <= 1'b0;
      case (state_r)
        SKIP: begin
          // Wait out any frame already in flight when reset released.
          if (!valid_i) begin
            state_r <= IDLE;
          end else begin
            state_r <= SKIP;
          end
        end
        IDLE: begin
          if (valid_i) begin
            state_r <= FRAME;
            crc_r   <= crc_next_s;
            count_r <= LEN_W'(1);
          end else begin
            state_r <= IDLE;
          end
        end
        FRAME: begin
          if (valid_i) begin
            crc_r <= crc_next_s;
            if (count_r != LEN_MAX_C) begin
              count_r <= count_r + LEN_W'(1);
            end else begin
              count_r <= count_r;
            end
            // Line already full: the oldest byte is payload, never FCS.
            if (count_r >= FCS_LEN_C) begin
              valid_o <= 1'b1;
              data_o  <= dl_data_r[3];
              er_o    <= dl_er_r[3];
            end else begin
              valid_o <= 1'b0;
            end
          end else begin
            state_r     <= IDLE;
            eof_o       <= 1'b1;
            fcs_error_o <= (crc_r != CRC32_RESIDUE) || (count_r <= FCS_LEN_C);
            runt_o      <= (count_r < MIN_LEN_C);
            frame_len_o <= count_r;
          end
        end
        default: begin
          state_r <= SKIP;
        end
      endcase
    end
  end

`ifdef RX_FCS_STATS_EN
  // Saturating frame and FCS-error counters, advanced the cycle after eof_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_frames_o  <= 32'd0;
      stat_fcs_err_o <= 32'd0;
    end else if (eof_o) begin
      if (stat_frames_o != 32'hFFFF_FFFF) begin
        stat_frames_o <= stat_frames_o + 32'd1;
      end else begin
        stat_frames_o <= stat_frames_o;
      end
      if (fcs_error_o && (stat_fcs_err_o != 32'hFFFF_FFFF)) begin
        stat_fcs_err_o <= stat_fcs_err_o + 32'd1;
      end else begin
        stat_fcs_err_o <= stat_fcs_err_o;
      end
    end else begin
      stat_frames_o  <= stat_frames_o;
      stat_fcs_err_o <= stat_fcs_err_o;
    end
  end
`endif

endmodule

// File: tb/tb_rx_fcs_check.sv
// Directed self-checking bench for rx_fcs_check.
module tb_rx_fcs_check;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [7:0]  data_i;
  logic        er_i;
  logic        valid_o;
  logic [7:0]  data_o;
  logic        er_o;
  logic        eof_o;
  logic        fcs_error_o;
  logic        runt_o;
  logic [15:0] frame_len_o;
`ifdef RX_FCS_STATS_EN
  logic [31:0] stat_frames_o;
  logic [31:0] stat_fcs_err_o;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int eof_a  = 0;
  int eof_b  = 0;

  logic [7:0] fr_d [0:127];
  logic       fr_e [0:127];

  rx_fcs_check #(.MIN_FRAME_LEN(64), .LEN_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .data_i      (data_i),
    .er_i        (er_i),
    .valid_o     (valid_o),
    .data_o      (data_o),
    .er_o        (er_o),
    .eof_o       (eof_o),
    .fcs_error_o (fcs_error_o),
    .runt_o      (runt_o),
    .frame_len_o (frame_len_o)
`ifdef RX_FCS_STATS_EN
    ,
    .stat_frames_o  (stat_frames_o),
    .stat_fcs_err_o (stat_fcs_err_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
    end
  endtask

  // Bit-serial reference CRC, LSB first.
  function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int b = 0; b < 8; b++) begin
      fb = r[0] ^ d[b];
      r  = {1'b0, r[31:1]};
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  // Payload pattern followed by a correct FCS (little-endian); no FCS below 4 bytes.
  task automatic build_frame(input int len);
    logic [31:0] c;
    logic [31:0] fcs;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 128; i++) fr_e[i] = 1'b0;
    if (len >= 4) begin
      for (int i = 0; i < len - 4; i++) begin
        fr_d[i] = 8'(i * 13 + 5);
        c = ref_crc(c, fr_d[i]);
      end
      fcs = ~c;
      fr_d[len-4] = fcs[7:0];
      fr_d[len-3] = fcs[15:8];
      fr_d[len-2] = fcs[23:16];
      fr_d[len-1] = fcs[31:24];
    end else begin
      for (int i = 0; i < len; i++) fr_d[i] = 8'(i * 13 + 5);
    end
  endtask

  task automatic send(input int len, input logic exp_fcs, input logic exp_runt);
    for (int j = 0; j < len; j++) begin
      valid_i = 1'b1;
      data_i  = fr_d[j];
      er_i    = fr_e[j];
      @(posedge clk); #1;
      chk("eof_mid", eof_o, 1'b0);
      if (j >= 4) begin
        chk("valid_fwd", valid_o, 1'b1);
        chk("data_fwd", data_o, fr_d[j-4]);
        chk("er_fwd", er_o, fr_e[j-4]);
      end else begin
        chk("valid_lead", valid_o, 1'b0);
      end
    end
    valid_i = 1'b0;
    data_i  = 8'd0;
    er_i    = 1'b0;
    @(posedge clk); #1;
    chk("valid_eof", valid_o, 1'b0);
    chk("eof", eof_o, 1'b1);
    chk("fcs_error", fcs_error_o, exp_fcs);
    chk("runt", runt_o, exp_runt);
    chk("frame_len", frame_len_o, 32'(len));
    eof_b = cyc;
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; data_i = 8'd0; er_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_eof", eof_o, 1'b0);
    chk("rst_fcs", fcs_error_o, 1'b0);
    chk("rst_runt", runt_o, 1'b0);
    chk("rst_len", frame_len_o, 32'd0);
    chk("rst_data", data_o, 8'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: good 64-byte frame
    build_frame(64);
    send(64, 1'b0, 1'b0);
    // 2: bit 0 of byte 20 flipped
    build_frame(64);
    fr_d[20] = fr_d[20] ^ 8'h01;
    send(64, 1'b1, 1'b0);
    // 3: 3-byte frame
    build_frame(3);
    send(3, 1'b1, 1'b1);
    // 4: 100-byte good frame with er on byte 30
    build_frame(100);
    fr_e[30] = 1'b1;
    send(100, 1'b0, 1'b0);
    // boundaries: 4-byte frame with matching CRC, 5-byte good, 63-byte good
    build_frame(4);
    send(4, 1'b1, 1'b1);
    build_frame(5);
    send(5, 1'b0, 1'b1);
    build_frame(63);
    send(63, 1'b0, 1'b1);

    // 5: reset at byte 10, released while valid_i still high
    build_frame(64);
    for (int j = 0; j < 10; j++) begin
      valid_i = 1'b1; data_i = fr_d[j];
      @(posedge clk); #1;
    end
    rst = 1'b1;
    for (int j = 10; j < 12; j++) begin
      data_i = fr_d[j];
      @(posedge clk); #1;
      chk("midrst_valid", valid_o, 1'b0);
      chk("midrst_eof", eof_o, 1'b0);
    end
    rst = 1'b0;
    for (int j = 12; j < 16; j++) begin
      data_i = fr_d[j];
      @(posedge clk); #1;
      chk("skip_valid", valid_o, 1'b0);
      chk("skip_eof", eof_o, 1'b0);
    end
    valid_i = 1'b0; data_i = 8'd0;
    @(posedge clk); #1;
    chk("skip_end_eof", eof_o, 1'b0);
    send(64, 1'b0, 1'b0);

    // 6: two good frames with one idle cycle between, after a fresh reset
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    build_frame(64);
    send(64, 1'b0, 1'b0);
    eof_a = eof_b;
    send(64, 1'b0, 1'b0);
    chk("eof_spacing", 32'(eof_b - eof_a), 32'd65);
    @(posedge clk); #1;
    chk("eof_drop", eof_o, 1'b0);
`ifdef RX_FCS_STATS_EN
    chk("stat_frames", stat_frames_o, 32'd2);
    chk("stat_fcs_err", stat_fcs_err_o, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_fcs_check.md
Name: rx_fcs_check

Overview:
Receive-path FCS checker between the preamble/SFD stripper and invalidate_packet.
- Consumes the post-SFD GMII byte stream and runs CRC-32 over every byte, including the FCS.
- Strips the trailing 4 FCS bytes from the forwarded stream.
- At end of frame, pulses fcs_error_o (drives invalidate_packet.fcs_error_i) together with a runt flag.

Parameters:
MIN_FRAME_LEN, 64, minimum legal frame length in bytes, FCS included; shorter frames flag runt_o.
LEN_W, 16, width of the internal byte counter; saturates at all-ones.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
valid_i  in  1  byte valid; contiguous for a whole frame, frame ends on first low cycle
data_i  in  8  frame byte (destination MAC first, FCS last)
er_i  in  1  GMII rx_er, sampled with valid_i
valid_o  out  1  forwarded byte valid (FCS bytes never forwarded)
data_o  out  8  forwarded byte
er_o  out  1  er_i delayed and aligned with data_o
eof_o  out  1  one-cycle end-of-frame pulse
fcs_error_o  out  1  pulse coincident with eof_o; 1 = bad FCS or frame of 4 bytes or fewer
runt_o  out  1  pulse coincident with eof_o; 1 = byte count < MIN_FRAME_LEN
frame_len_o  out  LEN_W  total received bytes incl. FCS; valid while eof_o=1

Behaviour:
- All outputs are registered. Reset value of every output is 0.
- CRC-32, reflected (LSB-first), polynomial 0xEDB88320, init 0xFFFFFFFF.
  - The register is updated once per valid byte.
  - A good frame leaves the register at residue 0xDEBB20E3 after its last FCS byte.
- States: SKIP (reset state), IDLE, FRAME.
  - SKIP: ignore input. Go to IDLE on the first cycle with valid_i=0. This covers reset asserted mid-frame or valid_i high at reset release.
  - IDLE: on valid_i=1, go to FRAME. Process the byte using the init value (the CRC is reloaded, not carried over). Set the byte count to 1.
  - FRAME, valid_i=1: update CRC, shift the byte into a 4-deep delay line, increment the count (saturating).
  - FRAME, valid_i=0 (cycle E): compare CRC to residue; go to IDLE.
- Delay line and output timing:
  - Holds the last 4 {data, er} pairs.
  - When valid_i=1 and the line is already full (count ≥ 4 before this byte), the oldest entry is registered to data_o/er_o with valid_o=1 on the next cycle.
  - Input byte k therefore appears on data_o the cycle after input byte k+4 is sampled: 5-cycle latency from the byte-0 sample.
  - A frame of N bytes produces max(N-4, 0) output bytes. The last output byte appears at cycle E.
- End of frame:
  - eof_o, fcs_error_o, runt_o and frame_len_o are registered at cycle E and visible at cycle E+1, i.e. one cycle after the last valid_o.
  - fcs_error_o = (crc != residue) || (count ≤ 4).
  - runt_o = count < MIN_FRAME_LEN.
- Back-to-back frames: a one-cycle gap is legal. eof_o for frame A and the first accepted byte of frame B's CRC occur in the same cycle, with no interaction.
- er_i does not affect fcs_error_o. It is only carried through to er_o, because invalidate_packet checks it separately.
- Counter saturation: count holds at 2^LEN_W-1; the CRC keeps running.
- Reset mid-frame: outputs clear at once, eof_o is never emitted for the truncated frame, and the state becomes SKIP.

Optional Feature:
Macro RX_FCS_STATS_EN.
- Defined:
  - Adds outputs stat_frames_o[31:0] and stat_fcs_err_o[31:0], both saturating and reset to 0.
  - stat_frames_o increments on every eof_o.
  - stat_fcs_err_o increments on eof_o with fcs_error_o=1.
  - Both update in the cycle after eof_o.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package eth_fcs_pkg holds:
  - CRC32_POLY, CRC32_INIT, CRC32_RESIDUE;
  - enum fcs_state_t {SKIP, IDLE, FRAME};
  - FCS_LEN=4.
- Sub-module crc32_d8: purely combinational, crc_i[31:0] + data_i[7:0] -> crc_o[31:0]. It is reused by the TX FCS inserter.

Test Plan:
1. 64-byte frame (60 payload + correct FCS) -> 60 valid_o bytes matching input bytes 0..59, first at 5 cycles after byte 0; eof_o one cycle after the last; fcs_error_o=0, runt_o=0, frame_len_o=64.
2. Same frame with bit 0 of byte 20 flipped -> identical data timing; fcs_error_o=1 with eof_o.
3. 3-byte frame -> no valid_o; eof_o with fcs_error_o=1, runt_o=1, frame_len_o=3.
4. 100-byte good frame with er_i=1 on byte 30 -> er_o=1 exactly with output byte 30; fcs_error_o=0.
5. rst asserted at byte 10 of a frame, released while valid_i is still high -> no outputs for that frame; next frame after the gap is good and checks clean.
6. Two 64-byte good frames separated by one idle cycle -> two eof_o pulses 65 cycles apart, both fcs_error_o=0. With RX_FCS_STATS_EN: stat_frames_o=2, stat_fcs_err_o=0.
